// File: rtl/commu_pkg.sv
// Shared types and constants for the UART-frame to fx-bus bridge.
package commu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_SEND
  } state_t;

  localparam logic [1:0] CMD_WR      = 2'b01;
  localparam logic [1:0] CMD_RD      = 2'b10;
  localparam int         CMD_FIX_BIT = 7;
  localparam logic [7:0] HDR_DEF     = 8'hA5;
  localparam logic [7:0] RSP_TAG_DEF = 8'hC3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/commu_tx_arb.sv
// Shared 16-bit tx channel owner: one word in flight, read responses beat pkg uploads.
module commu_tx_arb
  import commu_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        rsp_req,
  input  logic [15:0] rsp_data,
  output logic        rsp_ack,
  input  logic        pkg_vld,
  input  logic [15:0] pkg_d,
  output logic        pkg_done,
  output logic [15:0] tx_data,
  output logic        tx_vld,
  input  logic        tx_done
);

  logic        r_busy;
  logic        r_own_rsp;
  logic        r_tx_vld;
  logic [15:0] r_tx_data;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_own_rsp <= 1'b0;
      r_tx_vld  <= 1'b0;
      r_tx_data <= 16'h0;
    end else begin
      r_tx_vld <= 1'b0;
      // busy still reads 1 in the tx_done cycle, so a new launch lands one cycle later
      if (r_busy) begin
        if (tx_done) r_busy <= 1'b0;
      end else if (rsp_req) begin
        r_busy    <= 1'b1;
        r_own_rsp <= 1'b1;
        r_tx_vld  <= 1'b1;
        r_tx_data <= rsp_data;
      end else if (pkg_vld) begin
        r_busy    <= 1'b1;
        r_own_rsp <= 1'b0;
        r_tx_vld  <= 1'b1;
        r_tx_data <= pkg_d;
      end
    end
  end

  assign rsp_ack  = r_busy & tx_done & r_own_rsp;
  assign pkg_done = r_busy & tx_done & ~r_own_rsp;
  assign tx_vld   = r_tx_vld;
  assign tx_data  = r_tx_data;

endmodule

// File: rtl/commu_bridge.sv
// UART frame decoder driving the fx register bus, with paced read-back over the shared tx channel.
//   state      | meaning
//   S_IDLE     | hunting for the header byte
//   S_CMD      | expecting the command byte
//   S_ADDR     | collecting address bytes, MSB first
//   S_LEN      | expecting beat count minus one
//   S_WDATA    | one fx write per received data byte
//   S_RD_ISSUE | pulse fx_rd for the current beat
//   S_RD_WAIT  | wait out the read latency, capture fx_q
//   S_RD_SEND  | response word queued/in flight on tx
module commu_bridge
  import commu_pkg::*;
#(
  parameter int         AW         = 22,
  parameter int         ADDR_BYTES = 3,
  parameter int         RD_LAT     = 1,
  parameter int         TIMEOUT_US = 2000,
  parameter logic [7:0] HDR        = HDR_DEF,
  parameter logic [7:0] RSP_TAG    = RSP_TAG_DEF
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          pluse_us,
  input  logic [7:0]    rx_data,
  input  logic          rx_vld,
  output logic [15:0]   tx_data,
  output logic          tx_vld,
  input  logic          tx_done,
  output logic [AW-1:0] fx_waddr,
  output logic          fx_wr,
  output logic [7:0]    fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [7:0]    fx_q,
  input  logic [15:0]   pkg_d,
  input  logic          pkg_vld,
  output logic          pkg_done,
  output logic [7:0]    err_cnt
);

  localparam int AB_W = 8 * ADDR_BYTES;
  localparam int ACW  = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int GW   = $clog2(TIMEOUT_US + 1);

  state_t          r_state, w_state_nxt;
  logic            r_is_rd, r_fix;
  logic [ACW-1:0]  r_abyte;
  logic [AB_W-1:0] r_addr_acc;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_beats;
  logic [2:0]      r_lat;
  logic [GW-1:0]   r_gap;
  logic [7:0]      r_rsp_byte;
  logic [7:0]      r_err_cnt;
  logic            r_fx_wr, r_fx_rd;
  logic [AW-1:0]   r_fx_waddr, r_fx_raddr;
  logic [7:0]      r_fx_data;

  logic w_in_frame, w_tmo, w_abort, w_ld_cmd, w_shift_addr, w_ld_len;
  logic w_wr_beat, w_issue, w_capture, w_next_beat, w_rsp_req, w_rsp_ack;

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_LEN) || (r_state == S_WDATA);
  assign w_tmo      = w_in_frame && (r_gap == '0);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_abort      = 1'b0;
    w_ld_cmd     = 1'b0;
    w_shift_addr = 1'b0;
    w_ld_len     = 1'b0;
    w_wr_beat    = 1'b0;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    w_next_beat  = 1'b0;
    w_rsp_req    = 1'b0;
    case (r_state)
      S_IDLE: if (rx_vld && rx_data == HDR) w_state_nxt = S_CMD;
      S_CMD: begin
        if (w_tmo) w_abort = 1'b1;
        else if (rx_vld) begin
          if (rx_data[1:0] == CMD_WR || rx_data[1:0] == CMD_RD) begin
            w_ld_cmd    = 1'b1;
            w_state_nxt = S_ADDR;
          end else w_abort = 1'b1;
        end
      end
      S_ADDR: begin
        if (w_tmo) w_abort = 1'b1;
        else if (rx_vld) begin
          w_shift_addr = 1'b1;
          if (r_abyte == '0) w_state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (w_tmo) w_abort = 1'b1;
        else if (rx_vld) begin
          w_ld_len    = 1'b1;
          w_state_nxt = r_is_rd ? S_RD_ISSUE : S_WDATA;
        end
      end
      S_WDATA: begin
        if (w_tmo) w_abort = 1'b1;
        else if (rx_vld) begin
          w_wr_beat = 1'b1;
          if (r_beats == 8'd0) w_state_nxt = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_lat == 3'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RD_SEND;
        end
      end
      S_RD_SEND: begin
        w_rsp_req = 1'b1;
        if (w_rsp_ack) begin
          w_next_beat = 1'b1;
          w_state_nxt = (r_beats == 8'd0) ? S_IDLE : S_RD_ISSUE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_is_rd    <= 1'b0;
      r_fix      <= 1'b0;
      r_abyte    <= '0;
      r_addr_acc <= '0;
      r_addr     <= '0;
      r_beats    <= 8'd0;
      r_lat      <= 3'd0;
      r_gap      <= GW'(TIMEOUT_US);
      r_rsp_byte <= 8'd0;
      r_err_cnt  <= 8'd0;
      r_fx_wr    <= 1'b0;
      r_fx_rd    <= 1'b0;
      r_fx_waddr <= '0;
      r_fx_raddr <= '0;
      r_fx_data  <= 8'd0;
    end else begin
      r_fx_wr <= 1'b0;
      r_fx_rd <= 1'b0;
      if (w_ld_cmd) begin
        r_is_rd <= (rx_data[1:0] == CMD_RD);
        r_fix   <= rx_data[CMD_FIX_BIT];
        r_abyte <= ACW'(ADDR_BYTES - 1);
      end
      if (w_shift_addr) begin
        r_addr_acc <= (r_addr_acc << 8) | AB_W'(rx_data);
        r_abyte    <= r_abyte - 1'b1;
      end
      if (w_ld_len) begin
        r_beats <= rx_data;
        r_addr  <= r_addr_acc[AW-1:0];
      end
      if (w_wr_beat) begin
        r_fx_wr    <= 1'b1;
        r_fx_waddr <= r_addr;
        r_fx_data  <= rx_data;
      end
      if (w_wr_beat || w_next_beat) begin
        r_beats <= r_beats - 8'd1;
        if (!r_fix) r_addr <= r_addr + 1'b1;
      end
      if (w_issue) begin
        r_fx_rd    <= 1'b1;
        r_fx_raddr <= r_addr;
        r_lat      <= 3'(RD_LAT);
      end else if (r_state == S_RD_WAIT && r_lat != 3'd0) begin
        r_lat <= r_lat - 3'd1;
      end
      if (w_capture) r_rsp_byte <= fx_q;
      if (w_abort) r_err_cnt <= sat_inc8(r_err_cnt);
      // down-counter of idle microseconds left before the frame is abandoned
      if (!w_in_frame || rx_vld) r_gap <= GW'(TIMEOUT_US);
      else if (pluse_us && r_gap != '0) r_gap <= r_gap - 1'b1;
    end
  end

  commu_tx_arb u_tx_arb (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .rsp_req  (w_rsp_req),
    .rsp_data ({RSP_TAG, r_rsp_byte}),
    .rsp_ack  (w_rsp_ack),
    .pkg_vld  (pkg_vld),
    .pkg_d    (pkg_d),
    .pkg_done (pkg_done),
    .tx_data  (tx_data),
    .tx_vld   (tx_vld),
    .tx_done  (tx_done)
  );

  assign fx_wr    = r_fx_wr;
  assign fx_rd    = r_fx_rd;
  assign fx_waddr = r_fx_waddr;
  assign fx_raddr = r_fx_raddr;
  assign fx_data  = r_fx_data;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_commu_bridge.sv
// Scoreboard bench for commu_bridge: fx and tx phy models, queued expectations.
module tb_commu_bridge;

  localparam int AW      = 22;
  localparam int RD_LAT  = 2;
  localparam int TMO     = 40;
  localparam int PUL_DIV = 10;

  logic          clk_sys = 1'b0;
  logic          rst;
  logic          pluse_us;
  logic [7:0]    rx_data;
  logic          rx_vld;
  logic [15:0]   tx_data;
  logic          tx_vld;
  logic          tx_done;
  logic [AW-1:0] fx_waddr, fx_raddr;
  logic          fx_wr, fx_rd;
  logic [7:0]    fx_data, fx_q;
  logic [15:0]   pkg_d;
  logic          pkg_vld;
  logic          pkg_done;
  logic [7:0]    err_cnt;

  commu_bridge #(.AW(AW), .ADDR_BYTES(3), .RD_LAT(RD_LAT), .TIMEOUT_US(TMO)) dut (
    .clk_sys(clk_sys), .rst(rst), .pluse_us(pluse_us),
    .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_done(tx_done),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
    .pkg_d(pkg_d), .pkg_vld(pkg_vld), .pkg_done(pkg_done),
    .err_cnt(err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [AW+7:0] q_wr[$];
  logic [AW-1:0] q_rd[$];
  logic [15:0]   q_tx[$];
  logic [15:0]   pq[$];

  logic       tx_hold = 1'b0;
  logic       tx_pend;
  int         tx_cd;
  logic [7:0] fxval = 8'h00;
  int         rd_cd = 0;
  int         rd_seen = 0, rsp_done = 0, pd_cnt = 0, tx_cnt = 0;
  logic       inflight_rsp = 1'b0;
  logic       pd_flag = 1'b0;

  // pluse_us strobe every PUL_DIV cycles
  initial begin
    pluse_us = 1'b0;
    forever begin
      for (int i = 0; i < PUL_DIV; i++) begin
        @(posedge clk_sys); #1;
        pluse_us = (i == 0);
      end
    end
  end

  // tx phy: tx_done a few cycles after tx_vld, stalled while tx_hold
  initial begin
    tx_done = 1'b0;
    tx_pend = 1'b0;
    tx_cd   = 0;
    forever begin
      @(posedge clk_sys); #1;
      tx_done = 1'b0;
      if (rst) tx_pend = 1'b0;
      else begin
        if (tx_pend && !tx_hold) begin
          if (tx_cd == 0) begin
            tx_done = 1'b1;
            tx_pend = 1'b0;
          end else tx_cd--;
        end
        if (tx_vld) begin
          tx_pend = 1'b1;
          tx_cd   = 4;
        end
      end
    end
  end

  // pkg upload source: presents queue head until pkg_done
  initial begin
    pkg_vld = 1'b0;
    pkg_d   = 16'h0;
    forever begin
      @(posedge clk_sys); #1;
      if (pd_flag) begin
        pd_flag = 1'b0;
        if (pq.size() > 0) void'(pq.pop_front());
      end
      if (pq.size() > 0) begin
        pkg_vld = 1'b1;
        pkg_d   = pq[0];
      end else begin
        pkg_vld = 1'b0;
        pkg_d   = 16'h0;
      end
    end
  end

  // fx read model and output monitors
  always @(negedge clk_sys) begin
    if (rst) begin
      rd_seen      = 0;
      rsp_done     = 0;
      inflight_rsp = 1'b0;
      rd_cd        = 0;
    end else begin
      if (fx_rd) begin
        chk("rd_gate", 64'(rd_seen - rsp_done), 64'd0);
        rd_seen++;
        if (q_rd.size() == 0) chk("rd_unexp", 64'd1, 64'd0);
        else chk("rd_addr", 64'(fx_raddr), 64'(q_rd.pop_front()));
        fx_q  = 8'hEE;
        rd_cd = RD_LAT;
      end else if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          fx_q  = fxval;
          fxval = fxval + 8'd1;
        end
      end
      if (fx_wr) begin
        if (q_wr.size() == 0) chk("wr_unexp", 64'd1, 64'd0);
        else chk("wr_addr_data", 64'({fx_waddr, fx_data}), 64'(q_wr.pop_front()));
      end
      if (tx_vld && tx_done) chk("tx_overlap", 64'd1, 64'd0);
      if (tx_done && inflight_rsp) begin
        rsp_done++;
        inflight_rsp = 1'b0;
      end
      if (tx_vld) begin
        tx_cnt++;
        inflight_rsp = (tx_data[15:8] == 8'hC3);
        if (q_tx.size() == 0) chk("tx_unexp", 64'd1, 64'd0);
        else chk("tx_word", 64'(tx_data), 64'(q_tx.pop_front()));
      end
      if (pkg_done) begin
        pd_cnt++;
        pd_flag = 1'b1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_sys); #1;
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge clk_sys); #1;
    rx_vld  = 1'b0;
    repeat (2) @(posedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_idle(input int cyc);
    repeat (cyc) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int k;
    fx_q    = 8'h00;
    rx_data = 8'h00;
    rx_vld  = 1'b0;
    rst     = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_fx", 64'({fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr}), 64'd0);
    chk("rst_tx", 64'({tx_data, tx_vld, pkg_done, err_cnt}), 64'd0);
    rst = 1'b0;

    // write burst, auto-increment
    q_wr.push_back({22'h10, 8'h11});
    q_wr.push_back({22'h11, 8'h22});
    q_wr.push_back({22'h12, 8'h33});
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h10, 8'h02, 8'h11, 8'h22, 8'h33});
    wait_idle(10);
    chk("wr_burst_left", 64'(q_wr.size()), 64'd0);
    chk("wr_burst_err", 64'(err_cnt), 64'd0);

    // fixed-address read, two beats
    fxval = 8'h5A;
    q_rd.push_back(22'h100);
    q_rd.push_back(22'h100);
    q_tx.push_back(16'hC35A);
    q_tx.push_back(16'hC35B);
    send_frame('{8'hA5, 8'h82, 8'h00, 8'h01, 8'h00, 8'h01});
    k = 0;
    while (rsp_done < 2 && k < 300) begin @(posedge clk_sys); k++; end
    chk("rd_fix_done", 64'(rsp_done), 64'd2);
    chk("rd_fix_left", 64'(q_rd.size() + q_tx.size()), 64'd0);

    // arbitration: response pending when the pkg word 1111 completes
    tx_hold = 1'b1;
    q_tx.push_back(16'h1111);
    q_tx.push_back(16'hC35C);
    q_tx.push_back(16'hBEEF);
    q_rd.push_back(22'h20);
    pd_cnt = 0;
    pq.push_back(16'h1111);
    pq.push_back(16'hBEEF);
    wait_idle(4);
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h20, 8'h00});
    wait_idle(20);
    chk("arb_pd_held", 64'(pd_cnt), 64'd0);
    tx_hold = 1'b0;
    k = 0;
    while (pd_cnt < 2 && k < 300) begin @(posedge clk_sys); k++; end
    wait_idle(10);
    chk("arb_pd_cnt", 64'(pd_cnt), 64'd2);
    chk("arb_left", 64'(q_tx.size() + q_rd.size() + pq.size()), 64'd0);

    // inter-byte timeout then a normal frame
    send_frame('{8'hA5, 8'h01, 8'h00});
    wait_idle((TMO + 5) * PUL_DIV);
    chk("tmo_err", 64'(err_cnt), 64'd1);
    q_wr.push_back({22'h40, 8'h77});
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'h77});
    wait_idle(10);
    chk("tmo_next_left", 64'(q_wr.size()), 64'd0);
    chk("tmo_next_err", 64'(err_cnt), 64'd1);

    // bad command, stray bytes in IDLE, then address wrap
    send_frame('{8'hA5, 8'h03, 8'h00, 8'h11});
    wait_idle(4);
    chk("badcmd_err", 64'(err_cnt), 64'd2);
    q_wr.push_back({22'h3FFFFF, 8'hAA});
    q_wr.push_back({22'h000000, 8'hBB});
    send_frame('{8'hA5, 8'h01, 8'h3F, 8'hFF, 8'hFF, 8'h01, 8'hAA, 8'hBB});
    wait_idle(10);
    chk("wrap_left", 64'(q_wr.size()), 64'd0);
    chk("wrap_err", 64'(err_cnt), 64'd2);

    // reset while a response word is in flight
    tx_hold = 1'b1;
    fxval   = 8'h5D;
    q_rd.push_back(22'h30);
    q_tx.push_back(16'hC35D);
    k = tx_cnt;
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h30, 8'h00});
    wait_idle(20);
    chk("mid_launched", 64'(tx_cnt - k), 64'd1);
    @(negedge clk_sys);
    rst = 1'b1;
    #1;
    chk("mid_rst_fx", 64'({fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr}), 64'd0);
    chk("mid_rst_tx", 64'({tx_data, tx_vld, pkg_done, err_cnt}), 64'd0);
    repeat (3) @(posedge clk_sys);
    #1;
    rst     = 1'b0;
    tx_hold = 1'b0;
    q_wr.push_back({22'h50, 8'h99});
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h50, 8'h00, 8'h99});
    wait_idle(20);
    chk("post_rst_left", 64'(q_wr.size() + q_tx.size() + q_rd.size()), 64'd0);
    chk("post_rst_err", 64'(err_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/commu_bridge.md
Name: commu_bridge

Overview:
UART-frame to fx-bus bridge with a read-back path and an upload arbiter. It sits between the uart phy rx/tx pair and the fx register bus inside the communication top. It generalises the write-only fx master: parametrised address width, burst length, auto-increment and fixed addressing, read responses, inter-byte timeout, and arbitration of pkg upload words onto the shared 16-bit tx channel.

Parameters:
AW, 22, fx address width in bits (1..32)
ADDR_BYTES, 3, address bytes per frame, MSB first; must satisfy 8*ADDR_BYTES >= AW
RD_LAT, 1, cycles from fx_rd pulse to valid fx_q (1..4)
TIMEOUT_US, 2000, max pluse_us ticks allowed between rx bytes inside a frame
HDR, 8'hA5, frame header byte
RSP_TAG, 8'hC3, upper byte of every read-response tx word

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous active-high reset
pluse_us  in  1  1-cycle strobe every microsecond
rx_data  in  8  received byte from phy_urx
rx_vld  in  1  1-cycle strobe, rx_data valid
tx_data  out  16  word to the tx phy
tx_vld  out  1  1-cycle strobe, start transmit of tx_data
tx_done  in  1  1-cycle strobe, phy finished the current word
fx_waddr  out  AW  write address
fx_wr  out  1  1-cycle write strobe
fx_data  out  8  write data
fx_rd  out  1  1-cycle read strobe
fx_raddr  out  AW  read address
fx_q  in  8  read data, valid RD_LAT cycles after fx_rd
pkg_d  in  16  upload word
pkg_vld  in  1  level; held until pkg_done
pkg_done  out  1  1-cycle strobe, pkg word transmitted
err_cnt  out  8  aborted-frame count, saturating at 255

Behaviour:
- Reset: all outputs 0, FSM in IDLE, tx_busy 0. Reset mid-frame or mid-transmit discards everything; there is no resume.
- Frame format: HDR, CMD, ADDR_BYTES address bytes (MSB first, truncated to AW), LEN (beat count = LEN+1, 1..256), then LEN+1 data bytes for a write only.
- CMD: [1:0]=01 write, 10 read; [7]=1 fixed address, 0 auto-increment (address +1 mod 2^AW per beat). Any other [1:0] value aborts the frame.
- FSM states: IDLE -> (rx HDR) CMD -> ADDR -> LEN -> WDATA (write) or RD_ISSUE (read). In IDLE, non-HDR bytes are dropped silently.
- WDATA: each rx_vld drives fx_wr=1 for exactly 1 cycle on the next clock, with fx_waddr/fx_data registered. Returns to IDLE after the last beat.
- RD_ISSUE: fx_rd=1 for 1 cycle with fx_raddr. RD_WAIT lasts RD_LAT cycles, then captures fx_q into rsp_byte. RD_SEND waits for tx free, sends {RSP_TAG, rsp_byte}, and waits for tx_done. Then the next beat goes to RD_ISSUE, or the FSM returns to IDLE after the last beat.
- Only one read is outstanding at a time; the tx phy paces reads.
- rx bytes received during RD_* states are dropped and do not count as errors.
- Timeout: in CMD/ADDR/LEN/WDATA, a gap counter increments on pluse_us and clears on rx_vld. Reaching TIMEOUT_US causes abort to IDLE.
- Abort (timeout or bad CMD): return to IDLE, err_cnt+1 (saturating), no further fx strobes.
- tx channel: tx_busy is set on the cycle tx_vld is issued and cleared on tx_done. tx_vld is only issued when tx_busy=0. A tx_done and a new tx_vld may not occur in the same cycle; the new tx_vld goes out the cycle after tx_done.
- Arbitration when tx is free: a pending read response beats pkg_vld. A pkg word is sent as tx_data=pkg_d. pkg_done pulses on the tx_done of that word.
- pkg_vld dropped before pkg_done is a protocol error by the source; the word already launched still completes and pkg_done still pulses.
- Fixed-address read of N beats issues N fx_rd to the same address.

Decomposition:
- Package commu_pkg: FSM state enum, CMD_WR=2'b01, CMD_RD=2'b10, CMD_FIX_BIT=7, HDR and RSP_TAG defaults.
- One sub-module, commu_tx_arb: owns tx_busy, priority select, tx_vld/tx_data registers, and the pkg_done strobe. Its request interface is rsp_req/rsp_data/rsp_ack plus pkg_vld/pkg_d/pkg_done.
- The frame FSM, address counter, beat counter and timeout counter stay in commu_bridge.

Test Plan:
- Write burst: A5 01 00 00 10 02 11 22 33 -> three fx_wr pulses at addresses 0x10, 0x11, 0x12 with data 11, 22, 33; err_cnt stays 0.
- Fixed-address read, RD_LAT=2: fx model returns 0x5A, then 0x5B. Send A5 82 00 01 00 01 -> two fx_rd at 0x100; tx words C35A then C35B; second fx_rd only after the first tx_done.
- Arbitration: pkg_vld held with pkg_d=0xBEEF while a 1-beat read response becomes pending on the same cycle tx frees -> C3xx is sent first, BEEF next; pkg_done pulses once, after BEEF's tx_done.
- Timeout: A5 01 00, then no rx for TIMEOUT_US+5 pluse_us -> FSM returns to IDLE, err_cnt=1, no fx_wr. A following valid write frame executes normally.
- Bad CMD and wrap: A5 03 ... -> err_cnt+1. Then A5 01 3F FF FF 01 AA BB with AW=22 -> writes at 0x3FFFFF, then 0x000000.
- Reset mid-read: assert rst while in RD_SEND with tx_busy=1 -> all outputs 0 immediately. After release, a 1-beat write frame completes correctly.
